// File: rtl/wb_dffram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-DFFRAM512x32 bridge.
// The address-window check is enabled with WB_DFFRAM_BRIDGE_ADDR_CHECK_EN.
package wb_dffram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h3000_0000;
    localparam logic [31:0] DEF_WIN_MASK  = 32'hFFFF_F800;

endpackage

// File: rtl/wb_dffram512x32_bridge.sv
// Wishbone B4 classic slave driving one DFFRAM512x32 port (EN0/WE0/A0/Di0/Do0).
// Optional address-window check: define WB_DFFRAM_BRIDGE_ADDR_CHECK_EN.
module wb_dffram512x32_bridge
    import wb_dffram_bridge_pkg::*;
#(
    parameter int          A_WIDTH   = 9,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [31:0] WIN_MASK  = DEF_WIN_MASK
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WB_SELW-1:0]   wb_sel_i,
    input  logic [31:0]          wb_adr_i,
    input  logic [WB_DW-1:0]     wb_dat_i,
    output logic [WB_DW-1:0]     wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 ram_en0,
    output logic [WB_SELW-1:0]   ram_we0,
    output logic [A_WIDTH-1:0]   ram_a0,
    output logic [WB_DW-1:0]     ram_di0,
    input  logic [WB_DW-1:0]     ram_do0
);

    state_t state;
    logic   req;
    logic   hit;

`ifdef WB_DFFRAM_BRIDGE_ADDR_CHECK_EN
    assign hit = ((wb_adr_i & WIN_MASK) == BASE_ADDR);
`else
    logic unused_bits;
    assign hit         = 1'b1;
    assign unused_bits = ^{wb_adr_i[1:0], wb_adr_i[31:A_WIDTH+2], BASE_ADDR, WIN_MASK};
`endif

    // Gating with RST_N keeps the RAM idle while reset is held, even with a live strobe.
    assign req     = RST_N & wb_cyc_i & wb_stb_i & (state == IDLE);
    assign ram_en0 = req & hit;
    assign ram_we0 = (req & hit & wb_we_i) ? wb_sel_i : '0;
    assign ram_a0  = wb_adr_i[A_WIDTH+1:2];
    assign ram_di0 = wb_dat_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!hit) begin
                            wb_err_o <= 1'b1;
                            state    <= ACK;
                        end else if (wb_we_i) begin
                            wb_ack_o <= 1'b1;
                            state    <= ACK;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    // Master gave up while the RAM was fetching: drop the result silently.
                    if (wb_cyc_i && wb_stb_i) begin
                        wb_dat_o <= ram_do0;
                        wb_ack_o <= 1'b1;
                        state    <= ACK;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dffram512x32_bridge.sv
// Directed self-checking bench for wb_dffram512x32_bridge with a behavioural DFFRAM512x32.
module tb_wb_dffram512x32_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'h0;
    logic [31:0] wb_adr = '0, wb_dat = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        ram_en0;
    logic [3:0]  ram_we0;
    logic [8:0]  ram_a0;
    logic [31:0] ram_di0;
    logic [31:0] ram_do0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_dffram512x32_bridge dut (
        .CLK(clk), .RST_N(rst_n),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .ram_en0(ram_en0), .ram_we0(ram_we0), .ram_a0(ram_a0),
        .ram_di0(ram_di0), .ram_do0(ram_do0)
    );

    // Behavioural RAM: one-cycle read latency, Do0 forced to zero when EN0 is low.
    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (ram_en0) begin
            ram_do0 <= mem[ram_a0];
            for (int b = 0; b < 4; b++)
                if (ram_we0[b]) mem[ram_a0][b*8 +: 8] <= ram_di0[b*8 +: 8];
        end else begin
            ram_do0 <= '0;
        end
    end

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat, output int en_cnt,
                           output logic err, output logic [8:0] a_first, output logic [3:0] we_first);
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat = dat; wb_sel = sel;
        lat = 0; en_cnt = 0; err = 1'b0;
        #1;
        a_first  = ram_a0;
        we_first = ram_we0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            if (ram_en0) en_cnt++;
            @(negedge clk);
            if (wb_ack_o || wb_err_o) begin
                lat = i;
                err = wb_err_o;
            end else begin
                #1;
            end
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF; wb_adr = 32'h3000_0000;
        repeat (2) @(negedge clk);
        n_cmp++; if (ram_en0 !== 1'b0) begin n_bad++; $display("FAIL reset_en0: got %b want 0", ram_en0); end
        n_cmp++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack_err: got %b%b want 00", wb_ack_o, wb_err_o); end
        n_cmp++; if (wb_dat_o !== 32'h0) begin n_bad++; $display("FAIL reset_dat: got %h want 00000000", wb_dat_o); end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_release_ack: got %b want 0", wb_ack_o); end
    endtask

    task automatic test_write_read;
        int lat, en; logic err; logic [8:0] a; logic [3:0] w;
        wb_xfer(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, lat, en, err, a, w);
        n_cmp++; if (a !== 9'd4) begin n_bad++; $display("FAIL wr_a0: got %0d want 4", a); end
        n_cmp++; if (w !== 4'hF) begin n_bad++; $display("FAIL wr_we0: got %h want f", w); end
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL wr_latency: got %0d want 1", lat); end
        n_cmp++; if (en !== 1) begin n_bad++; $display("FAIL wr_en_pulses: got %0d want 1", en); end
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, en, err, a, w);
        n_cmp++; if (w !== 4'h0) begin n_bad++; $display("FAIL rd_we0: got %h want 0", w); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rd_latency: got %0d want 2", lat); end
        n_cmp++; if (wb_dat_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", wb_dat_o); end
        @(negedge clk);
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL ack_single_cycle: got %b want 0", wb_ack_o); end
    endtask

    task automatic test_byte_lanes;
        int lat, en; logic err; logic [8:0] a; logic [3:0] w;
        wb_xfer(1'b1, 32'h3000_0010, 32'h1122_3344, 4'b0101, lat, en, err, a, w);
        n_cmp++; if (w !== 4'b0101) begin n_bad++; $display("FAIL lane_we0: got %b want 0101", w); end
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, en, err, a, w);
        n_cmp++; if (wb_dat_o !== 32'hDE22_BE44) begin n_bad++; $display("FAIL lane_data: got %h want de22be44", wb_dat_o); end
        wb_xfer(1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'b0000, lat, en, err, a, w);
        n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL sel0_ack: got latency %0d want 1", lat); end
        n_cmp++; if (en !== 1 || w !== 4'h0) begin n_bad++; $display("FAIL sel0_ram: got en %0d we %h want en 1 we 0", en, w); end
        n_cmp++; if (wb_dat_o !== 32'hDE22_BE44) begin n_bad++; $display("FAIL sel0_dat_hold: got %h want de22be44", wb_dat_o); end
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, en, err, a, w);
        n_cmp++; if (wb_dat_o !== 32'hDE22_BE44) begin n_bad++; $display("FAIL sel0_data: got %h want de22be44", wb_dat_o); end
    endtask

    task automatic test_back_to_back;
        int lat, en; logic err; logic [8:0] a; logic [3:0] w;
        int en_cnt, n_ack;
        int ack_c [2];
        logic [31:0] ack_d [2];
        logic [8:0] en_a [2];
        wb_xfer(1'b1, 32'h3000_0000, 32'h0BAD_F00D, 4'hF, lat, en, err, a, w);
        wb_xfer(1'b1, 32'h3000_07FC, 32'hCAFE_01FF, 4'hF, lat, en, err, a, w);
        en_cnt = 0; n_ack = 0;
        ack_c = '{-1, -1}; ack_d = '{32'h0, 32'h0}; en_a = '{9'h0, 9'h0};
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_sel = 4'hF; wb_adr = 32'h3000_0000;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (wb_ack_o) begin
                if (n_ack < 2) begin ack_c[n_ack] = c; ack_d[n_ack] = wb_dat_o; end
                n_ack++;
                wb_adr = 32'h3000_07FC;
            end
            #1;
            if (ram_en0) begin
                if (en_cnt < 2) en_a[en_cnt] = ram_a0;
                en_cnt++;
            end
            if (c == 5) begin wb_cyc = 1'b0; wb_stb = 1'b0; end
        end
        n_cmp++; if (en_cnt !== 2) begin n_bad++; $display("FAIL b2b_en_pulses: got %0d want 2", en_cnt); end
        n_cmp++; if (n_ack !== 2) begin n_bad++; $display("FAIL b2b_ack_count: got %0d want 2", n_ack); end
        n_cmp++; if (ack_c[0] !== 2 || ack_c[1] !== 5) begin n_bad++; $display("FAIL b2b_ack_spacing: got %0d,%0d want 2,5", ack_c[0], ack_c[1]); end
        n_cmp++; if (en_a[0] !== 9'd0 || en_a[1] !== 9'd511) begin n_bad++; $display("FAIL b2b_addr: got %0d,%0d want 0,511", en_a[0], en_a[1]); end
        n_cmp++; if (ack_d[0] !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL b2b_data0: got %h want 0badf00d", ack_d[0]); end
        n_cmp++; if (ack_d[1] !== 32'hCAFE_01FF) begin n_bad++; $display("FAIL b2b_data511: got %h want cafe01ff", ack_d[1]); end
    endtask

    task automatic test_abort;
        int lat, en; logic err; logic [8:0] a; logic [3:0] w;
        logic seen_ack;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h3000_0010;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        seen_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (wb_ack_o) seen_ack = 1'b1;
        end
        n_cmp++; if (seen_ack !== 1'b0) begin n_bad++; $display("FAIL abort_no_ack: got %b want 0", seen_ack); end
        n_cmp++; if (wb_dat_o !== 32'hCAFE_01FF) begin n_bad++; $display("FAIL abort_dat_hold: got %h want cafe01ff", wb_dat_o); end
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, en, err, a, w);
        n_cmp++; if (lat !== 2 || wb_dat_o !== 32'hDE22_BE44) begin n_bad++; $display("FAIL abort_recover: got lat %0d dat %h want lat 2 dat de22be44", lat, wb_dat_o); end
    endtask

    task automatic test_addr_window;
        int lat, en; logic err; logic [8:0] a; logic [3:0] w;
        wb_xfer(1'b0, 32'h3000_0800, 32'h0, 4'hF, lat, en, err, a, w);
`ifdef WB_DFFRAM_BRIDGE_ADDR_CHECK_EN
        n_cmp++; if (err !== 1'b1 || lat !== 1) begin n_bad++; $display("FAIL win_err: got err %b lat %0d want err 1 lat 1", err, lat); end
        n_cmp++; if (en !== 0) begin n_bad++; $display("FAIL win_no_ram: got %0d pulses want 0", en); end
        n_cmp++; if (wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL win_no_ack: got %b want 0", wb_ack_o); end
        n_cmp++; if (wb_dat_o !== 32'hDE22_BE44) begin n_bad++; $display("FAIL win_dat_hold: got %h want de22be44", wb_dat_o); end
        @(negedge clk);
        n_cmp++; if (wb_err_o !== 1'b0) begin n_bad++; $display("FAIL win_err_single: got %b want 0", wb_err_o); end
`else
        n_cmp++; if (err !== 1'b0 || lat !== 2) begin n_bad++; $display("FAIL alias_ack: got err %b lat %0d want err 0 lat 2", err, lat); end
        n_cmp++; if (en !== 1 || a !== 9'd0) begin n_bad++; $display("FAIL alias_ram: got en %0d a0 %0d want en 1 a0 0", en, a); end
        n_cmp++; if (wb_dat_o !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL alias_data: got %h want 0badf00d", wb_dat_o); end
        n_cmp++; if (wb_err_o !== 1'b0) begin n_bad++; $display("FAIL alias_err: got %b want 0", wb_err_o); end
`endif
    endtask

    task automatic test_reset_mid;
        int lat, en; logic err; logic [8:0] a; logic [3:0] w;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_sel = 4'hF;
        wb_adr = 32'h3000_0024; wb_dat = 32'h1234_5678;
        #1;
        n_cmp++; if (ram_en0 !== 1'b1) begin n_bad++; $display("FAIL mid_pre_en0: got %b want 1", ram_en0); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ram_en0 !== 1'b0 || ram_we0 !== 4'h0) begin n_bad++; $display("FAIL mid_en0: got en %b we %h want 0 0", ram_en0, ram_we0); end
        n_cmp++; if (wb_dat_o !== 32'h0 || wb_ack_o !== 1'b0) begin n_bad++; $display("FAIL mid_outputs: got dat %h ack %b want 0 0", wb_dat_o, wb_ack_o); end
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        rst_n = 1'b1;
        wb_xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, lat, en, err, a, w);
        n_cmp++; if (lat !== 2 || wb_dat_o !== 32'hDE22_BE44) begin n_bad++; $display("FAIL mid_contents: got lat %0d dat %h want lat 2 dat de22be44", lat, wb_dat_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_back_to_back();
        test_abort();
        test_addr_window();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_dffram512x32_bridge.md
Name: wb_dffram512x32_bridge

Overview:
Wishbone B4 classic slave that fronts one 512x32 DFFRAM macro and sits directly upstream of it. It drives the RAM's CLK-domain EN0/WE0/A0/Di0 port and captures the RAM's one-cycle-latency Do0. The RAM zeroes Do0 whenever EN0 is low, so the bridge holds its own read-data register. It translates classic cyc/stb handshakes into single RAM accesses with byte-lane writes.

Parameters:
A_WIDTH, 9, RAM word-address width (RAM depth = 2**A_WIDTH words)
BASE_ADDR, 32'h3000_0000, byte base address of the RAM window (used only with the optional feature)
WIN_MASK, 32'hFFFF_F800, mask selecting the bits compared against BASE_ADDR

Ports:
CLK  input  1  single clock; also clocks the RAM
RST_N  input  1  asynchronous, active-low reset
wb_cyc_i  input  1  bus cycle valid
wb_stb_i  input  1  strobe
wb_we_i  input  1  1 = write
wb_sel_i  input  4  byte lane selects
wb_adr_i  input  32  byte address; word index = wb_adr_i[A_WIDTH+1:2]
wb_dat_i  input  32  write data
wb_dat_o  output  32  read data, registered
wb_ack_o  output  1  single-cycle acknowledge
wb_err_o  output  1  error response (tied 0 when the optional feature is off)
ram_en0  output  1  to RAM EN0
ram_we0  output  4  to RAM WE0
ram_a0  output  A_WIDTH  to RAM A0
ram_di0  output  32  to RAM Di0
ram_do0  input  32  from RAM Do0; valid one cycle after the EN0 edge

Behaviour:
- Reset (async assert, sync release): state=IDLE; wb_ack_o=0, wb_err_o=0, wb_dat_o=0. ram_en0/ram_we0 go to 0 immediately.
- req = wb_cyc_i & wb_stb_i & (state==IDLE).
- RAM drive is combinational from the bus:
  - ram_a0 = wb_adr_i[A_WIDTH+1:2]; ram_di0 = wb_dat_i.
  - ram_en0 = req; ram_we0 = req & wb_we_i ? wb_sel_i : 4'b0.
- FSM states: IDLE, RD, ACK.
  - IDLE, write req: RAM writes at this edge -> ACK. wb_ack_o=1 in the next cycle only. Write latency: ack 1 cycle after the request cycle.
  - IDLE, read req: RAM samples at this edge -> RD.
  - RD: wb_dat_o <= ram_do0; wb_ack_o <= 1 -> ACK. Read latency: ack 2 cycles after the request cycle.
  - ACK: ack is high for exactly this cycle; no RAM access even if stb is still high -> IDLE.
- Throughput: write 2 cycles per access; read 3 cycles per access.
- wb_dat_o holds the last read data until the next read completes; writes do not change it.
- Write with wb_sel_i=0: ram_en0=1, no bytes written, still acked.
- cyc or stb low while in RD: abort, go to IDLE with no ack and wb_dat_o unchanged. A write already committed at its edge is not undone.
- Reset mid-access: immediate IDLE, ack dropped. RAM contents are not cleared.
- Address bits [1:0] and those above A_WIDTH+1 are ignored; the address aliases over the whole space.
- ram_en0 is never high in RD or ACK, so the RAM sees at most one access per transaction.

Optional Feature:
Macro WB_DFFRAM_BRIDGE_ADDR_CHECK_EN.
- Defined: hit = ((wb_adr_i & WIN_MASK) == BASE_ADDR). A request with !hit causes no RAM access (ram_en0=0), goes to ACK, and asserts wb_err_o (not wb_ack_o) for one cycle. A hit request behaves as in the base spec.
- Undefined: no compare; every request is a hit, and wb_err_o is constant 0.

Decomposition:
- Package wb_dffram_bridge_pkg:
  - state enum {IDLE, RD, ACK} (2-bit)
  - WB_DW=32, WB_SELW=4
  - default BASE_ADDR/WIN_MASK constants
- No sub-module inside the bridge. A separate top (wb_dffram512x32) instantiates the bridge plus DFFRAM512x32, sharing CLK.

Test Plan:
1. Reset with RST_N=0 mid-stream -> ack/err/dat_o=0 and ram_en0=0 immediately; after release, state IDLE.
2. Write 0xDEADBEEF, sel=4'hF, adr 0x3000_0010 -> ram_a0=4, ram_we0=F in the request cycle, ack the next cycle. Read the same address -> ack 2 cycles later, wb_dat_o=0xDEADBEEF.
3. Byte-lane write 0x11223344 with sel=4'b0101 over 0xDEADBEEF -> read returns 0xDE22BE44. A write with sel=0 is acked and the read is unchanged.
4. Hold stb high through ack for back-to-back reads of words 0 and 511 -> exactly one ram_en0 pulse per transaction, ack pulses spaced 3 cycles apart, data correct at the wrap edge (adr 0x3000_07FC -> ram_a0=511).
5. Drop cyc in RD -> no ack, wb_dat_o keeps its previous value, next access normal.
6. With WB_DFFRAM_BRIDGE_ADDR_CHECK_EN: access 0x3000_0800 -> wb_err_o=1 for one cycle, ram_en0 never high. Without the macro, the same address aliases to word 0 and is acked.
